// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory responder for the single-cycle core.
// Performs byte/half/word loads and stores against an internal word array after a
// configurable number of wait states, holding the core with stall while busy.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   mem_read_en            load request
//   mem_write_en           store request (wins if both requests are high)
//   funct3                 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata            byte address and store data
//   rdata                  extended load result (registered)
//   stall                  core must hold PC and inputs while high
//   done                   one-cycle completion pulse
//   misalign               fault flag, valid while done is high
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [IdxW+1:0]   addr_q;
  logic [31:0]       wdata_q;
  logic              fault_q;
  logic [31:0]       rdata_q;

  logic              req;
  logic              req_fault;
  logic [31:0]       word;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_data;
  logic [3:0]        be;
  logic [31:0]       wdata_al;

  logic [31:0]       mem [DEPTH_WORDS];

  // Upper address bits wrap away; they are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^addr[31:IdxW+2];

  assign req = mem_read_en | mem_write_en;

  always_comb begin
    req_fault = 1'b0;
    if (mem_write_en) begin
      req_fault = (funct3 > 3'b010) || (funct3 == 3'b001 && addr[0]) ||
                  (funct3 == 3'b010 && addr[1:0] != 2'b00);
    end else begin
      // 011, 110, 111 are not loads; 001/101 need half alignment.
      req_fault = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                  (funct3[1:0] == 2'b01 && addr[0]) ||
                  (funct3 == 3'b010 && addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          stall = 1'b1;
          if (req_fault) begin
            state_d = StResp;
          end else if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = StAccess;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAccess: begin
        stall   = 1'b1;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Load path: lane select and extension.
  always_comb begin
    word = mem[addr_q[IdxW+1:2]];
    case (addr_q[1:0])
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_q[1] ? word[31:16] : word[15:0];
    case (funct3_q[1:0])
      2'b00:   load_data = funct3_q[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_data = funct3_q[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase
  end

  // Store path: replicate data across lanes, enable only the addressed ones.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_q[1:0];
        wdata_al = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{wdata_q[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_al = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StIdle && req) begin
        store_q  <= mem_write_en;
        funct3_q <= funct3;
        addr_q   <= addr[IdxW+1:0];
        wdata_q  <= wdata;
        fault_q  <= req_fault;
        if (req_fault) begin
          rdata_q <= 32'h0;
        end
      end
      if (state_q == StAccess && !store_q) begin
        rdata_q <= load_data;
      end
    end
  end

  // Array is not reset.
  always_ff @(posedge clk) begin
    if (state_q == StAccess && store_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr_q[IdxW+1:2]][8*i +: 8] <= wdata_al[8*i +: 8];
        end
      end
    end
  end

  assign rdata    = rdata_q;
  assign done     = (state_q == StResp);
  assign misalign = (state_q == StResp) & fault_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: two instances (2 wait states and 0 wait
// states), directed vector table, reset-in-WAIT sequence, and random accesses
// checked against a byte-addressed reference model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        re [2];
  logic        we [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd_o [2];
  logic        st_o [2];
  logic        dn_o [2];
  logic        mis_o [2];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_read_en(re[0]), .mem_write_en(we[0]), .funct3(f3[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rd_o[0]), .stall(st_o[0]), .done(dn_o[0]),
    .misalign(mis_o[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_read_en(re[1]), .mem_write_en(we[1]), .funct3(f3[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rd_o[1]), .stall(st_o[1]), .done(dn_o[1]),
    .misalign(mis_o[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory as plain bytes, 1024 bytes per instance.
  logic [7:0]  ref_mem [2][1024];
  logic [31:0] ref_rdata [2];
  int          wc [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input int d, input logic wr, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] w, output logic fault);
    int n;
    int base;
    logic [31:0] v;
    n = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    if (wr) fault = (f > 3'd2) || (f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'd0);
    else fault = (f == 3'd3 || f == 3'd6 || f == 3'd7) || ((f == 3'd1 || f == 3'd5) && a[0]) ||
                 (f == 3'd2 && a[1:0] != 2'd0);
    if (fault) begin
      ref_rdata[d] = 32'h0;
      return;
    end
    base = int'(a % 32'd1024);
    if (wr) begin
      for (int i = 0; i < n; i++) ref_mem[d][base + i] = w[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][base + i]) << (8 * i));
      if (n < 4 && !f[2] && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      ref_rdata[d] = v;
    end
  endtask

  task automatic access(input int d, input logic wr, input logic rq, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] w, input string tag,
                        output logic [31:0] got_rd, output logic got_mis);
    logic fault;
    int   stall_n;
    int   c;
    int   exp_c;
    bit   seen;
    model(d, wr, f, a, w, fault);
    @(negedge clk);
    we[d] = wr; re[d] = rq; f3[d] = f; ad[d] = a; wd[d] = w;
    #1;
    stall_n = 0;
    seen    = 1'b0;
    c       = 0;
    while (c < 40) begin
      if (st_o[d]) stall_n++;
      if (dn_o[d]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      c++;
    end
    got_rd  = rd_o[d];
    got_mis = mis_o[d];
    we[d] = 1'b0; re[d] = 1'b0;
    exp_c = fault ? 1 : wc[d] + 2;
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " done cycle"}, 32'(c), 32'(exp_c));
    check({tag, " stall cycles"}, 32'(stall_n), 32'(exp_c));
    check({tag, " rdata model"}, got_rd, ref_rdata[d]);
    check({tag, " misalign model"}, 32'(got_mis), 32'(fault));
  endtask

  typedef struct {
    int          d;
    logic        wr;
    logic        rq;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] exp_rd;
    logic        exp_mis;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] got_rd;
    logic        got_mis;
    wc[0] = 2;
    wc[1] = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; re[d] = 1'b0; we[d] = 1'b0; f3[d] = 3'b0; ad[d] = 32'h0; wd[d] = 32'h0;
      ref_rdata[d] = 32'h0;
    end

    // Directed vectors: {dut, write, read, funct3, addr, wdata, rdata, misalign}.
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b000, 32'h11, 32'h80, 32'hDEADBEEF, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b100, 32'h11, 32'h0, 32'h00000080, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h12345678, 32'hDEAD80EF, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b001, 32'h22, 32'h8001, 32'hDEAD80EF, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b101, 32'h22, 32'h0, 32'h00008001, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0, 32'h80015678, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b010, 32'h00, 32'hA5A5A5A5, 32'h80015678, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h02, 32'h0, 32'h0, 1'b1});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h00, 32'h0, 32'hA5A5A5A5, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b010, 32'h04, 32'h11112222, 32'hA5A5A5A5, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b001, 32'h05, 32'hFFFF, 32'h0, 1'b1});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h04, 32'h0, 32'h11112222, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0});
    vt.push_back(vec_t'{0, 1'b1, 1'b0, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1});
    vt.push_back(vec_t'{0, 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 32'h0, 1'b0});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b110, 32'h30, 32'h0, 32'h0, 1'b1});
    vt.push_back(vec_t'{0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h0, 32'hCAFEF00D, 1'b0});
    vt.push_back(vec_t'{1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h600DCAFE, 32'h0, 1'b0});
    vt.push_back(vec_t'{1, 1'b0, 1'b1, 3'b010, 32'h000, 32'h0, 32'h600DCAFE, 1'b0});
    vt.push_back(vec_t'{1, 1'b0, 1'b1, 3'b000, 32'h403, 32'h0, 32'h00000060, 1'b0});
    vt.push_back(vec_t'{1, 1'b0, 1'b1, 3'b101, 32'h402, 32'h0, 32'h0000600D, 1'b0});
    vt.push_back(vec_t'{1, 1'b1, 1'b0, 3'b010, 32'h002, 32'h12345678, 32'h0, 1'b1});
    vt.push_back(vec_t'{1, 1'b0, 1'b1, 3'b010, 32'h000, 32'h0, 32'h600DCAFE, 1'b0});

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset rdata d%0d", d), rd_o[d], 32'h0);
      check($sformatf("reset stall d%0d", d), 32'(st_o[d]), 32'h0);
      check($sformatf("reset done d%0d", d), 32'(dn_o[d]), 32'h0);
      check($sformatf("reset misalign d%0d", d), 32'(mis_o[d]), 32'h0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // No request: stays idle.
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle stall", 32'(st_o[0] | st_o[1]), 32'h0);
      check("idle done", 32'(dn_o[0] | dn_o[1]), 32'h0);
    end

    foreach (vt[i]) begin
      access(vt[i].d, vt[i].wr, vt[i].rq, vt[i].f, vt[i].a, vt[i].w, $sformatf("vec%0d", i),
             got_rd, got_mis);
      check($sformatf("vec%0d rdata", i), got_rd, vt[i].exp_rd);
      check($sformatf("vec%0d misalign", i), 32'(got_mis), 32'(vt[i].exp_mis));
    end

    // Reset during WAIT of a store: store must not land, next load completes.
    @(negedge clk);
    we[0] = 1'b1; f3[0] = 3'b010; ad[0] = 32'h10; wd[0] = 32'h0BADF00D;
    @(negedge clk);
    #1;
    check("rst-wait stall before", 32'(st_o[0]), 32'h1);
    we[0]  = 1'b0;
    rst[0] = 1'b1;
    #1;
    check("rst-wait stall", 32'(st_o[0]), 32'h0);
    check("rst-wait done", 32'(dn_o[0]), 32'h0);
    check("rst-wait rdata", rd_o[0], 32'h0);
    ref_rdata[0] = 32'h0;
    @(negedge clk);
    rst[0] = 1'b0;
    access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0, "rst-wait reload", got_rd, got_mis);
    check("rst-wait word unchanged", got_rd, 32'hDEAD80EF);

    // Random traffic against the model; fill a 16-word window first.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        access(d, 1'b1, 1'b0, 3'b010, 32'(4 * i), $urandom, $sformatf("init d%0d", d),
               got_rd, got_mis);
      end
      for (int i = 0; i < 60; i++) begin
        int unsigned kind;
        logic [31:0] a;
        kind = $urandom_range(0, 2);
        a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
        access(d, kind != 0, kind != 1, 3'($urandom_range(0, 7)), a, $urandom,
               $sformatf("rand d%0d #%0d", d, i), got_rd, got_mis);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the single-cycle core. It consumes the memory control signals issued by the control unit (`mem_read_en`, `mem_write_en`) together with `funct3`, the ALU-computed address and the rs2 store data. It executes LB/LH/LW/LBU/LHU/SB/SH/SW against an internal word-organised array with a configurable number of wait states. While the access is in flight it holds the core with `stall`.

## Interface
- `DEPTH_WORDS`, default 256: number of 32-bit words in the array; power of two, at least 4.
- `WAIT_CYCLES`, default 2: wait states before the array access; legal range 0..15.
- `clk` in 1: the only clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read_en` in 1: load request from the control unit.
- `mem_write_en` in 1: store request from the control unit.
- `funct3` in 3: access size and sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `addr` in 32: byte address (ALU result).
- `wdata` in 32: store data.
- `rdata` out 32: extended load result.
- `stall` out 1: the core must hold PC and all inputs while high.
- `done` out 1: one-cycle pulse marking access completion.
- `misalign` out 1: fault flag, valid only while `done` is high.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- A request is `mem_read_en | mem_write_en`. If both are high, the access is a store.
- **IDLE:**
  - On a request, latch op, `funct3`, `addr` and `wdata`.
  - If the access is illegal, go to RESP with the fault flag set.
  - Otherwise go to WAIT if `WAIT_CYCLES` > 0, else to ACCESS.
- **Illegal accesses:**
  - H/HU/SH with `addr[0]` = 1.
  - W/SW with `addr[1:0]` != 0.
  - Load `funct3` of 011, 110 or 111.
  - Store `funct3` greater than 010.
- **WAIT:** a 4-bit counter loads `WAIT_CYCLES` - 1 on entry and decrements each cycle. The FSM goes to ACCESS in the cycle the counter is 0.
- **ACCESS:**
  - The word index is `addr[2 +: log2(DEPTH_WORDS)]`; upper address bits are ignored, so addresses wrap modulo the array size.
  - Store:
    - SB writes `wdata[7:0]` into lane `addr[1:0]`.
    - SH writes `wdata[15:0]` into lanes {`addr[1]`, 0} and {`addr[1]`, 1}.
    - SW writes all four lanes.
    - Unselected lanes are unchanged.
  - Load:
    - B and H select the lane(s) and sign-extend.
    - BU and HU zero-extend.
    - W passes the full word.
    - The result is registered into `rdata` at the end of ACCESS.
  - Next state is RESP.
- **RESP:**
  - `done` = 1 and `misalign` = fault flag.
  - Inputs are ignored.
  - Next state is IDLE unconditionally, so the same instruction is never re-accepted.
- **Fault path:** no array write occurs and `rdata` is cleared to 0.
- **Store path:** `rdata` keeps its previous value.
- **Reset:**
  - Async `rst` forces IDLE, counter = 0, `rdata` = 0, `done` = 0, `misalign` = 0 and the fault flag = 0.
  - Array contents are not reset; an interrupted store may or may not have landed only if `rst` hits during ACCESS.

## Timing
- `stall` is combinational: (IDLE & request) | WAIT | ACCESS.
- `stall` is low in RESP, so the core advances at the end of the RESP cycle.
- Legal access with the request seen in IDLE at cycle 0:
  - WAIT occupies cycles 1..`WAIT_CYCLES`.
  - ACCESS is cycle `WAIT_CYCLES` + 1.
  - RESP (`done`, `rdata` valid) is cycle `WAIT_CYCLES` + 2.
- Faulting access: RESP is cycle 1.
- `stall` is high for exactly `WAIT_CYCLES` + 2 cycles on a legal access and 1 cycle on a fault.
- No request: the block stays in IDLE with `stall` = 0 and `done` = 0.
- Minimum spacing between back-to-back requests: the next request is accepted at the earliest in the cycle after RESP.
- `rdata` is stable from RESP until the next load or fault reaches ACCESS/RESP.

## Test plan
- SW `wdata` = 0xDEADBEEF at `addr` 0x10, then LW at 0x10 with `WAIT_CYCLES` = 2 -> `stall` high for 4 cycles on each access, `done` in cycle 4, `rdata` = 0xDEADBEEF, `misalign` = 0.
- SB 0x80 at 0x11, then LB at 0x11 -> `rdata` = 0xFFFFFF80; LBU at 0x11 -> 0x00000080; LW at 0x10 -> 0xDEAD80EF.
- SH 0x8001 at 0x22, then LH at 0x22 -> `rdata` = 0xFFFF8001; LHU -> 0x00008001; LW at 0x20 -> upper half 0x8001, lower half unchanged.
- LW at 0x02, and separately SH at 0x05 -> `done` and `misalign` in cycle 1, array unchanged (checked by reading back), `rdata` = 0 after the LW fault.
- `rst` pulsed during WAIT of an SW -> `stall` and `done` drop immediately, state returns to IDLE, target word unchanged, next LW completes normally.
- `WAIT_CYCLES` = 0 with `DEPTH_WORDS` = 256: SW at 0x400 then LW at 0x000 -> same word returned (address wrap), `done` in cycle 2 of each access.
